// File: rtl/button_conditioner.sv
// Turns raw, bouncing push-buttons into clean debounced levels plus one-cycle
// press, release and hold-to-repeat pulses; every bit is an independent channel.
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 400,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic               single_pulse_clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        REPEATING
    } btn_state_t;

    logic [NUM_BTN-1:0] sync_s1;
    logic [NUM_BTN-1:0] sync_s2;

    always_ff @(posedge single_pulse_clk or posedge reset) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make s2 take the old s1, giving a true two-stage chain.
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_state_t        state_q, state_d;
        logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              level_q, level_d;
        logic              pulse_q, pulse_d;
        logic              release_q, release_d;
        logic              toggle;

        always_ff @(posedge single_pulse_clk or posedge reset) begin
            if (reset) begin
                state_q   <= RELEASED;
                db_cnt_q  <= '0;
                hold_q    <= '0;
                level_q   <= 1'b0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                hold_q    <= hold_d;
                level_q   <= level_d;
                pulse_q   <= pulse_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            // NOTE: every signal gets a default first so no path through the block infers a latch.
            state_d   = state_q;
            db_cnt_d  = db_cnt_q;
            hold_d    = hold_q;
            level_d   = level_q;
            pulse_d   = 1'b0;
            release_d = 1'b0;
            toggle    = 1'b0;

            if (sync_s2[i] == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_d = '0;
                level_d  = ~level_q;
                toggle   = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end

            // A debounced fall wins over any repeat tick due on the same edge.
            case (state_q)
                RELEASED: begin
                    if (toggle) begin
                        state_d = PRESSED;
                        pulse_d = 1'b1;
                        hold_d  = '0;
                    end
                end
                PRESSED: begin
                    if (toggle) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                        hold_d    = '0;
                    end else if (hold_q == DELAY_LAST) begin
                        if (repeat_en[i]) begin
                            state_d = REPEATING;
                            pulse_d = 1'b1;
                            hold_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                REPEATING: begin
                    if (toggle) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                        hold_d    = '0;
                    end else if (hold_q == PERIOD_LAST) begin
                        if (repeat_en[i]) begin
                            pulse_d = 1'b1;
                            hold_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    hold_d  = '0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_pulse[i]   = pulse_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed test-plan scenarios followed by random bouncing/holding, all compared
// against a window-based reference model of debounce, press, release and repeat.
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int HN = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] raw;
    logic [NB-1:0] ren;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_release;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [NB-1:0] raw_hist  [HN];
    logic [NB-1:0] obs_level [HN];
    logic [NB-1:0] obs_pulse [HN];
    logic [NB-1:0] obs_rel   [HN];

    logic [NB-1:0] m_level;
    logic [NB-1:0] exp_pulse;
    logic [NB-1:0] exp_rel;
    int            last_pulse [NB];
    bit            repeated   [NB];

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .single_pulse_clk(clk),
        .reset(reset),
        .btn_raw(raw),
        .repeat_en(ren),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Raw value sampled at a given edge since reset release; before edge 1 the
    // synchroniser holds zeros.
    function automatic logic hist_bit(input int idx, input int b);
        if (idx < 1) return 1'b0;
        return raw_hist[idx][b];
    endfunction

    task automatic model_clear();
        n       = 0;
        m_level = '0;
        for (int b = 0; b < NB; b++) begin
            last_pulse[b] = 0;
            repeated[b]   = 1'b0;
        end
    endtask

    // The debouncer at edge n judges the raw samples of edges n-2 .. n-DB-1; the
    // level flips when all of them disagree with the current level.
    task automatic model_edge();
        logic all_differ;
        int   gap;
        for (int b = 0; b < NB; b++) begin
            exp_pulse[b] = 1'b0;
            exp_rel[b]   = 1'b0;
            all_differ   = 1'b1;
            for (int k = 0; k < DB; k++)
                if (hist_bit(n - 2 - k, b) == m_level[b]) all_differ = 1'b0;
            if (all_differ) begin
                if (!m_level[b]) begin
                    m_level[b]    = 1'b1;
                    exp_pulse[b]  = 1'b1;
                    last_pulse[b] = n;
                    repeated[b]   = 1'b0;
                end else begin
                    m_level[b] = 1'b0;
                    exp_rel[b] = 1'b1;
                end
            end else if (m_level[b]) begin
                gap = repeated[b] ? RP : RD;
                if (ren[b] && (n - last_pulse[b]) >= gap) begin
                    exp_pulse[b]  = 1'b1;
                    last_pulse[b] = n;
                    repeated[b]   = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        raw_hist[n] = raw;
        model_edge();
        #1;
        obs_level[n] = btn_level;
        obs_pulse[n] = btn_pulse;
        obs_rel[n]   = btn_release;
        check($sformatf("level@%0d", n), btn_level, m_level);
        check($sformatf("pulse@%0d", n), btn_pulse, exp_pulse);
        check($sformatf("release@%0d", n), btn_release, exp_rel);
        check($sformatf("pulse_and_release@%0d", n), btn_pulse & btn_release, '0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        raw   = '0;
        ren   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_level", btn_level, '0);
        check("reset_pulse", btn_pulse, '0);
        check("reset_release", btn_release, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int   n0;
        logic acc;
        logic exp_b;

        reset = 1'b1;
        raw   = '0;
        ren   = '0;
        model_clear();
        apply_reset();

        // Scenario 1: single press on btnU, no repeat.
        raw[1] = 1'b1;
        repeat (12) tick();
        check("sc1_pulse@5", obs_pulse[5], 5'b00000);
        check("sc1_pulse@6", obs_pulse[6], 5'b00010);
        check("sc1_level@6", obs_level[6], 5'b00010);
        check("sc1_pulse@7", obs_pulse[7], 5'b00000);

        // Scenario 4: release of btnU.
        n0     = n;
        raw[1] = 1'b0;
        repeat (8) tick();
        check("sc4_release@5", obs_rel[n0 + 5], 5'b00000);
        check("sc4_release@6", obs_rel[n0 + 6], 5'b00010);
        check("sc4_level@5", obs_level[n0 + 5], 5'b00010);
        check("sc4_level@6", obs_level[n0 + 6], 5'b00000);

        // Scenario 2: btnD bouncing 1,1,1,0 never gets through.
        n0 = n;
        for (int i = 0; i < 40; i++) begin
            raw[4] = ((i % 4) != 3);
            tick();
        end
        acc = 1'b0;
        for (int e = n0 + 1; e <= n; e++)
            acc = acc | obs_level[e][4] | obs_pulse[e][4] | obs_rel[e][4];
        check("sc2_quiet", {4'b0, acc}, 5'b00000);
        raw[4] = 1'b0;
        repeat (6) tick();

        // Scenario 3: btnD held with repeat enabled.
        apply_reset();
        raw[4] = 1'b1;
        ren[4] = 1'b1;
        repeat (30) tick();
        for (int e = 1; e <= 30; e++) begin
            exp_b = (e == 6) || (e >= 14 && ((e - 14) % 3) == 0);
            check($sformatf("sc3_pulse@%0d", e), {4'b0, obs_pulse[e][4]}, {4'b0, exp_b});
        end
        raw = '0;
        ren = '0;
        repeat (8) tick();

        // Scenario 5: btnC and btnR together, then release btnC only.
        n0     = n;
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        repeat (8) tick();
        check("sc5_pulse@6", obs_pulse[n0 + 6], 5'b01001);
        check("sc5_level@6", obs_level[n0 + 6], 5'b01001);
        raw[0] = 1'b0;
        repeat (10) tick();
        check("sc5_level_after_release", obs_level[n], 5'b01000);

        // Scenario 6: asynchronous reset in the middle of a held btnR.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("sc6_async_level", btn_level, '0);
        check("sc6_async_pulse", btn_pulse, '0);
        check("sc6_async_release", btn_release, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        repeat (8) tick();
        check("sc6_pulse@5", obs_pulse[5], 5'b00000);
        check("sc6_pulse@6", obs_pulse[6], 5'b01000);

        // Random bouncing, holding and repeat-enable toggling on all channels.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(9) == 0) raw[b] = ~raw[b];
                if ($urandom_range(15) == 0) ren[b] = ~ren[b];
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw Basys3 push-buttons into clean single-cycle pulses for the menu and display stages: btnU/btnD for menu navigation, btnC for select.
- Runs on single_pulse_clk, the same clock that downstream menu logic samples btnU/btnD on.
- Per-button path: 2-FF synchroniser, stable-count debouncer, press/release edge pulses, optional hold-to-repeat.

Parameters:
- NUM_BTN, 5, number of buttons. Bit map: 0=btnC, 1=btnU, 2=btnL, 3=btnR, 4=btnD.
- DEBOUNCE_CYCLES, 4, consecutive differing synchronised samples required to flip the debounced level. Must be >=1.
- REPEAT_DELAY, 400, cycles from the press pulse to the first repeat pulse. Must be >=1.
- REPEAT_PERIOD, 100, cycles between subsequent repeat pulses. Must be >=1.

Ports:
- single_pulse_clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw, asynchronous, bouncing button inputs.
- repeat_en  input  NUM_BTN  per-button hold-to-repeat enable; synchronous to single_pulse_clk.
- btn_level  output  NUM_BTN  debounced button level, registered.
- btn_pulse  output  NUM_BTN  one-cycle pulse on debounced press and on each repeat tick, registered.
- btn_release  output  NUM_BTN  one-cycle pulse on debounced release, registered.

Behaviour:
- Clocking and reset: one clock, single_pulse_clk. Reset is asynchronous and active-high, named reset. While reset is high, all of the following are 0: sync stages, debounce counters, hold counters, btn_level, btn_pulse, btn_release. After reset deasserts, all buttons read as released.
- Channel independence: each bit is a fully independent channel. Simultaneous activity on several buttons produces simultaneous, independent outputs.
- Synchroniser: s1 <= btn_raw; s2 <= s1. Only s2 feeds the debouncer.
- Debouncer, per bit:
  - If s2 == btn_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
  - Counter width: clog2(DEBOUNCE_CYCLES+1).
- Latency: btn_raw held high from sampling edge 1 makes btn_level rise on edge DEBOUNCE_CYCLES+2. btn_pulse rises on that same edge and is high for exactly 1 cycle. The release path is symmetric and produces btn_release.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES consecutive s2 samples resets the counter and never changes btn_level.
- Per-button states: RELEASED, PRESSED, REPEATING.
  - RELEASED -> PRESSED: on debounced rise; emit btn_pulse; hold_cnt <= 0.
  - PRESSED: hold_cnt increments every cycle.
  - PRESSED -> REPEATING: when hold_cnt == REPEAT_DELAY-1 and repeat_en=1; emit btn_pulse; hold_cnt <= 0.
  - REPEATING: when hold_cnt == REPEAT_PERIOD-1 and repeat_en=1, emit btn_pulse and clear hold_cnt.
  - PRESSED or REPEATING -> RELEASED: on debounced fall; emit btn_release; no btn_pulse that cycle.
- hold_cnt behaviour:
  - Counts whenever the button is held, regardless of repeat_en.
  - Saturates at its terminal value while repeat_en=0.
  - If repeat_en asserts after saturation, a repeat pulse fires on the next edge.
  - Width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Output guarantees: btn_pulse and btn_release are never both high on the same bit. btn_pulse never exceeds 1 cycle per event.
- Reset mid-press: all channels return to RELEASED with outputs 0. A button still physically held after reset needs a full debounce before it produces a pulse.

Test Plan (overrides: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
1. Reset, then btn_raw[1]=1 held → btn_level[1]=1 and btn_pulse[1]=1 on edge 6 only. btn_pulse[1]=0 from edge 7 while held, repeat_en=0.
2. btn_raw[4] toggles 1,1,1,0,1,1,1,0 repeating → btn_level[4], btn_pulse[4] and btn_release[4] stay 0 indefinitely.
3. repeat_en[4]=1 with btn_raw[4] held 30 cycles → press pulse at edge 6, repeat pulses at edges 14, 17, 20, 23, 26, 29 (relative to the first high sample).
4. Release after scenario 1 → btn_release[1] single pulse 6 edges after btn_raw[1] falls. btn_level[1]=0 on the same edge.
5. btn_raw[0] and btn_raw[3] rise on the same edge → btn_pulse[0] and btn_pulse[3] both assert on edge 6. Release of one leaves the other's btn_level unaffected.
6. Assert reset asynchronously mid-hold (between edges) → all outputs 0 immediately. With btn_raw still high after reset deasserts, btn_pulse asserts on edge 6 after the first sampling edge.
